// File: rtl/board_array.sv
// board_array: N x N game board with a live copy, a save-on-demand shadow copy for display,
// a move counter and a sequential K-in-a-row checker that scans only the lines through the last mark.
module board_array #(
   parameter int N   = 3,
   parameter int WIN = 3,
   parameter int AW  = $clog2(N*N)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clear,
   input  logic          wen,
   input  logic [AW-1:0] waddr,
   input  logic [1:0]    wdata,
   output logic          wready,
   output logic          werr,
   output logic [1:0]    wrdata,
   input  logic          save,
   input  logic [AW-1:0] raddr,
   output logic [1:0]    rdata,
   output logic [1:0]    winner,
   output logic          draw,
   output logic          gameover,
   output logic          done,
   output logic          gameover_vga
);
   localparam int CELLS = N*N;
   localparam int CW    = $clog2(CELLS+1);
   localparam int RCW   = $clog2(N);
   localparam int KW    = $clog2(WIN);
   localparam int RW    = $clog2(2*WIN);
   localparam int SW    = 8;

   typedef enum logic {IDLE, CHECK} state_t;
   state_t state, state_nxt;

   logic [1:0]     live   [CELLS];
   logic [1:0]     shadow [CELLS];
   logic [CW-1:0]  moves;
   logic [RCW-1:0] row, col;
   logic [1:0]     mark;
   logic [1:0]     dir;
   logic           half;
   logic [KW-1:0]  k;
   logic [RW-1:0]  run;
   logic           broken, hit;

   logic                 addr_ok, accept, reject;
   logic signed [SW-1:0] off, r0, c0, pr, pc;
   logic                 inb, match, first, brk_eff, last_step, final_step, hit_new;
   logic [AW-1:0]        pidx;
   logic [RW-1:0]        run_base, run_new;

   assign gameover = (winner != 2'b00) || draw;
   assign wready   = (state == IDLE);

   // One probe per cycle: cell at signed offset k along the current direction.
   always_comb begin
      addr_ok = int'(waddr) < CELLS;
      wrdata  = addr_ok ? live[waddr] : 2'b00;
      rdata   = (int'(raddr) < CELLS) ? shadow[raddr] : 2'b00;

      off = half ? -SW'(k) : SW'(k);
      r0  = SW'(row);
      c0  = SW'(col);
      pr  = r0;
      pc  = c0;
      case (dir)
         2'd0:    pc = c0 + off;
         2'd1:    pr = r0 + off;
         2'd2:    begin pr = r0 + off; pc = c0 + off; end
         default: begin pr = r0 + off; pc = c0 - off; end
      endcase
      inb   = !pr[SW-1] && !pc[SW-1] && (pr < SW'(N)) && (pc < SW'(N));
      pidx  = inb ? AW'(int'(pr) * N + int'(pc)) : '0;
      match = inb && (live[pidx] == mark);

      first      = (k == KW'(1));
      brk_eff    = first ? 1'b0 : broken;
      run_base   = (first && !half) ? RW'(1) : run;
      run_new    = run_base + RW'(match && !brk_eff);
      last_step  = half && (k == KW'(WIN-1));
      final_step = last_step && (dir == 2'd3);
      hit_new    = hit || (last_step && (run_new >= RW'(WIN)));
   end

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      reject    = 1'b0;
      if (clear) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE: if (wen) begin
               if (addr_ok && (wdata == 2'b01 || wdata == 2'b10) && wrdata == 2'b00 && !gameover) begin
                  accept    = 1'b1;
                  state_nxt = CHECK;
               end else begin
                  reject = 1'b1;
               end
            end
            default: if (final_step) state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         live         <= '{default: '0};
         shadow       <= '{default: '0};
         moves        <= '0;
         row          <= '0;
         col          <= '0;
         mark         <= '0;
         dir          <= '0;
         half         <= 1'b0;
         k            <= '0;
         run          <= '0;
         broken       <= 1'b0;
         hit          <= 1'b0;
         winner       <= '0;
         draw         <= 1'b0;
         werr         <= 1'b0;
         done         <= 1'b0;
         gameover_vga <= 1'b0;
      end else begin
         if (save) begin
            shadow       <= live;
            gameover_vga <= gameover;
         end
         werr <= reject;
         done <= 1'b0;
         if (clear) begin
            live   <= '{default: '0};
            moves  <= '0;
            winner <= '0;
            draw   <= 1'b0;
            hit    <= 1'b0;
         end else if (accept) begin
            live[waddr] <= wdata;
            moves       <= moves + CW'(1);
            row         <= RCW'(int'(waddr) / N);
            col         <= RCW'(int'(waddr) % N);
            mark        <= wdata;
            dir         <= '0;
            half        <= 1'b0;
            k           <= KW'(1);
            run         <= RW'(1);
            broken      <= 1'b0;
         end else if (state == CHECK) begin
            run    <= run_new;
            broken <= brk_eff || !match;
            hit    <= hit_new;
            if (k == KW'(WIN-1)) begin
               k    <= KW'(1);
               half <= ~half;
               if (half) dir <= dir + 2'd1;
            end else begin
               k <= k + KW'(1);
            end
            if (final_step) begin
               done <= 1'b1;
               if (hit_new)                   winner <= mark;
               else if (moves == CW'(CELLS))  draw   <= 1'b1;
            end
         end
      end
   end
endmodule
